// File: rtl/tile_ram_arbiter.sv
// Single-port arbiter for the 80x30 text/tile RAM: video fetch > clear-screen engine > CPU.
// Video reads return after a fixed one-cycle latency; the CPU is acked one cycle after its grant.
module tile_ram_arbiter #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 30,
  parameter int          ADDR_W     = 12,
  parameter logic [15:0] CLEAR_WORD = 16'h0020
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [15:0]       vid_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [15:0]       cpu_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [15:0]       ram_din,
  input  logic [15:0]       ram_dout
);

  localparam int                TOTAL    = COLS * ROWS;
  localparam logic [ADDR_W:0]   TOTAL_W  = (ADDR_W + 1)'(TOTAL);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  typedef enum logic [0:0] {IDLE, CLEAR} clr_state_t;

  clr_state_t        state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_next;
  logic [ADDR_W-1:0] addr_hold;
  logic              grant_vid, grant_clr, grant_cpu;
  logic              vld_p1, vid_ok_p1, ack_p1, cpu_rd_p1;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < TOTAL_W;
  endfunction

  assign clr_busy = (state == CLEAR);

  // Grants are suppressed while reset is held so nothing reaches the RAM mid-reset.
  always_comb begin
    grant_vid = !reset && vid_req;
    grant_clr = !reset && !vid_req && clr_busy;
    grant_cpu = !reset && !vid_req && !clr_busy && cpu_req && !ack_p1;
  end

  // Stage p0: RAM port mux for the winning requester
  always_comb begin
    ram_addr = reset ? '0 : addr_hold;
    ram_we   = 1'b0;
    ram_din  = '0;
    if (grant_vid) begin
      ram_addr = vid_addr;
    end else if (grant_clr) begin
      ram_addr = ptr;
      ram_we   = 1'b1;
      ram_din  = CLEAR_WORD;
    end else if (grant_cpu) begin
      ram_addr = cpu_addr;
      ram_we   = cpu_we && in_range(cpu_addr);
      ram_din  = cpu_wdata;
    end
  end

  // Stage p1: read data returns from the RAM; qualify it for video and CPU
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      vid_ok_p1 <= 1'b0;
      ack_p1    <= 1'b0;
      cpu_rd_p1 <= 1'b0;
      addr_hold <= '0;
    end else begin
      vld_p1    <= grant_vid;
      vid_ok_p1 <= grant_vid && in_range(vid_addr);
      ack_p1    <= grant_cpu;
      cpu_rd_p1 <= grant_cpu && !cpu_we && in_range(cpu_addr);
      if (grant_vid || grant_clr || grant_cpu)
        addr_hold <= ram_addr;
    end
  end

  assign vid_valid = vld_p1;
  assign vid_rdata = vid_ok_p1 ? ram_dout : '0;
  assign cpu_ack   = ack_p1;
  assign cpu_rdata = cpu_rd_p1 ? ram_dout : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // The pointer only moves on cycles the clear actually owns the port.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end
      end
      CLEAR: begin
        if (grant_clr) begin
          if (ptr == LAST_PTR) begin
            state_next = IDLE;
            ptr_next   = '0;
          end else begin
            ptr_next = ptr + PTR_ONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Directed bench for tile_ram_arbiter: cycle-by-cycle vector table plus long clear/reset sequences,
// with a behavioural synchronous RAM attached to the RAM port.
module tb_tile_ram_arbiter;

  logic        clk;
  logic        reset;
  logic        vid_req;
  logic [11:0] vid_addr;
  logic        vid_valid;
  logic [15:0] vid_rdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [11:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        clr_start;
  logic        clr_busy;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;

  logic [15:0] mem [0:4095];
  logic        fill;

  int n_cmp;
  int n_bad;

  tile_ram_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_valid (vid_valid),
    .vid_rdata (vid_rdata),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input int i);
    return 16'h5A00 ^ 16'(i);
  endfunction

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic        vr;
    logic [11:0] va;
    logic        cr;
    logic        cw;
    logic [11:0] ca;
    logic [15:0] cd;
    logic        cs;
    logic        we;
    logic [11:0] addr;
    logic [15:0] din;
    logic        vv;
    logic [15:0] vd;
    logic        ack;
    logic [15:0] crd;
    logic        busy;
  } vec_t;

  vec_t vecs [27];

  function automatic vec_t mk(input int vr, input int va, input int cr, input int cw, input int ca,
                              input int cd, input int cs, input int we, input int addr, input int din,
                              input int vv, input int vd, input int ack, input int crd, input int busy);
    vec_t r;
    r.vr = 1'(vr);  r.va = 12'(va);     r.cr = 1'(cr);   r.cw = 1'(cw);  r.ca = 12'(ca);
    r.cd = 16'(cd); r.cs = 1'(cs);      r.we = 1'(we);   r.addr = 12'(addr);
    r.din = 16'(din); r.vv = 1'(vv);    r.vd = 16'(vd);  r.ack = 1'(ack);
    r.crd = 16'(crd); r.busy = 1'(busy);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    vid_req   = 1'b0;
    vid_addr  = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    clr_start = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, stolen, ack_cnt, vv_err, ack_c, bad_lo, bad_hi, bad;
    logic busy_seen, busy_done, ack_ok, prev_vr, found;

    n_cmp = 0;
    n_bad = 0;
    idle_inputs();
    reset = 1'b1;
    fill  = 1'b1;
    next_cycle();
    fill = 1'b0;
    @(negedge clk);
    chk("rst.vid_valid", 32'(vid_valid), 0);
    chk("rst.vid_rdata", 32'(vid_rdata), 0);
    chk("rst.cpu_ack",   32'(cpu_ack), 0);
    chk("rst.cpu_rdata", 32'(cpu_rdata), 0);
    chk("rst.clr_busy",  32'(clr_busy), 0);
    chk("rst.ram_addr",  32'(ram_addr), 0);
    chk("rst.ram_we",    32'(ram_we), 0);
    chk("rst.ram_din",   32'(ram_din), 0);
    next_cycle();
    reset = 1'b0;

    //               vr va     cr cw ca     cd       cs  we addr   din      vv vd       ack crd      busy
    vecs[0]  = mk(0, 0,      0, 0, 0,     0,       0,  0, 0,     0,       0, 0,       0, 0,       0);
    vecs[1]  = mk(0, 0,      1, 1, 0,     'h1C41,  0,  1, 0,     'h1C41,  0, 0,       0, 0,       0);
    vecs[2]  = mk(0, 0,      1, 1, 0,     'h1C41,  0,  0, 0,     0,       0, 0,       1, 0,       0);
    vecs[3]  = mk(0, 0,      1, 0, 0,     0,       0,  0, 0,     0,       0, 0,       0, 0,       0);
    vecs[4]  = mk(0, 0,      0, 0, 0,     0,       0,  0, 0,     0,       0, 0,       1, 'h1C41,  0);
    vecs[5]  = mk(1, 3,      1, 0, 5,     0,       0,  0, 3,     0,       0, 0,       0, 0,       0);
    vecs[6]  = mk(0, 0,      1, 0, 5,     0,       0,  0, 5,     0,       1, 'h5A03,  0, 0,       0);
    vecs[7]  = mk(0, 0,      1, 0, 5,     0,       0,  0, 5,     0,       0, 0,       1, 'h5A05,  0);
    vecs[8]  = mk(1, 'h960,  0, 0, 0,     0,       0,  0, 'h960, 0,       0, 0,       0, 0,       0);
    vecs[9]  = mk(0, 0,      0, 0, 0,     0,       0,  0, 'h960, 0,       1, 0,       0, 0,       0);
    vecs[10] = mk(0, 0,      1, 1, 'h960, 'hBEEF,  0,  0, 'h960, 'hBEEF,  0, 0,       0, 0,       0);
    vecs[11] = mk(0, 0,      1, 1, 'h960, 'hBEEF,  0,  0, 'h960, 0,       0, 0,       1, 0,       0);
    vecs[12] = mk(0, 0,      1, 0, 'hFFF, 0,       0,  0, 'hFFF, 0,       0, 0,       0, 0,       0);
    vecs[13] = mk(0, 0,      0, 0, 0,     0,       0,  0, 'hFFF, 0,       0, 0,       1, 0,       0);
    vecs[14] = mk(0, 0,      1, 1, 7,     'h1234,  0,  1, 7,     'h1234,  0, 0,       0, 0,       0);
    vecs[15] = mk(0, 0,      1, 1, 7,     'h1234,  0,  0, 7,     0,       0, 0,       1, 0,       0);
    vecs[16] = mk(0, 0,      1, 1, 7,     'h1234,  0,  1, 7,     'h1234,  0, 0,       0, 0,       0);
    vecs[17] = mk(0, 0,      1, 1, 7,     'h1234,  0,  0, 7,     0,       0, 0,       1, 0,       0);
    vecs[18] = mk(0, 0,      1, 1, 7,     'h1234,  0,  1, 7,     'h1234,  0, 0,       0, 0,       0);
    vecs[19] = mk(0, 0,      1, 1, 7,     'h1234,  0,  0, 7,     0,       0, 0,       1, 0,       0);
    vecs[20] = mk(0, 0,      0, 0, 0,     0,       0,  0, 7,     0,       0, 0,       0, 0,       0);
    vecs[21] = mk(0, 0,      1, 0, 7,     0,       0,  0, 7,     0,       0, 0,       0, 0,       0);
    vecs[22] = mk(0, 0,      0, 0, 0,     0,       0,  0, 7,     0,       0, 0,       1, 'h1234,  0);
    vecs[23] = mk(0, 0,      1, 1, 9,     'h0A0A,  1,  1, 9,     'h0A0A,  0, 0,       0, 0,       0);
    vecs[24] = mk(0, 0,      1, 1, 9,     'h0A0A,  0,  1, 0,     'h0020,  0, 0,       1, 0,       1);
    vecs[25] = mk(1, 1,      0, 0, 0,     0,       0,  0, 1,     0,       0, 0,       0, 0,       1);
    vecs[26] = mk(0, 0,      0, 0, 0,     0,       0,  1, 1,     'h0020,  1, 'h5A01,  0, 0,       1);

    for (int i = 0; i < 27; i++) begin
      vid_req   = vecs[i].vr;
      vid_addr  = vecs[i].va;
      cpu_req   = vecs[i].cr;
      cpu_we    = vecs[i].cw;
      cpu_addr  = vecs[i].ca;
      cpu_wdata = vecs[i].cd;
      clr_start = vecs[i].cs;
      @(negedge clk);
      chk($sformatf("v%0d.ram_we", i),    32'(ram_we),    32'(vecs[i].we));
      chk($sformatf("v%0d.ram_addr", i),  32'(ram_addr),  32'(vecs[i].addr));
      chk($sformatf("v%0d.ram_din", i),   32'(ram_din),   32'(vecs[i].din));
      chk($sformatf("v%0d.vid_valid", i), 32'(vid_valid), 32'(vecs[i].vv));
      chk($sformatf("v%0d.vid_rdata", i), 32'(vid_rdata), 32'(vecs[i].vd));
      chk($sformatf("v%0d.cpu_ack", i),   32'(cpu_ack),   32'(vecs[i].ack));
      chk($sformatf("v%0d.cpu_rdata", i), 32'(cpu_rdata), 32'(vecs[i].crd));
      chk($sformatf("v%0d.clr_busy", i),  32'(clr_busy),  32'(vecs[i].busy));
      next_cycle();
    end

    // Remaining clear from the table: pointer already at 2
    idle_inputs();
    busy_cnt  = 0;
    busy_done = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (clr_busy) busy_cnt++;
      else begin
        busy_done = 1'b1;
        break;
      end
      next_cycle();
    end
    next_cycle();
    chk("drain.done", 32'(busy_done), 1);
    chk("drain.busy_cycles", 32'(busy_cnt), 2398);

    // Full clear with video every 8th cycle and a CPU write queued behind it
    fill = 1'b1;
    next_cycle();
    fill      = 1'b0;
    busy_cnt  = 0;
    stolen    = 0;
    ack_cnt   = 0;
    vv_err    = 0;
    ack_c     = 0;
    busy_seen = 1'b0;
    busy_done = 1'b0;
    ack_ok    = 1'b1;
    prev_vr   = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      clr_start = (c == 0);
      vid_req   = (c % 8 == 0);
      vid_addr  = 12'd100;
      if (c == 3) begin
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 12'd10;
        cpu_wdata = 16'h7777;
      end
      if (ack_cnt > 0) cpu_req = 1'b0;
      @(negedge clk);
      if (vid_valid !== prev_vr) vv_err++;
      prev_vr = vid_req;
      if (clr_busy) begin
        busy_seen = 1'b1;
        busy_cnt++;
        if (vid_req) stolen++;
      end else if (busy_seen) begin
        busy_done = 1'b1;
      end
      if (cpu_ack) begin
        ack_cnt++;
        ack_c = c;
        if (!busy_done || clr_busy) ack_ok = 1'b0;
      end
      next_cycle();
      if (busy_done && ack_cnt > 0 && c > ack_c + 3) break;
    end
    idle_inputs();
    next_cycle();
    chk("clrA.done", 32'(busy_done), 1);
    chk("clrA.stolen_nonzero", 32'(stolen > 0), 1);
    chk("clrA.busy_cycles", 32'(busy_cnt), 32'(2400 + stolen));
    chk("clrA.ack_count", 32'(ack_cnt), 1);
    chk("clrA.ack_after_clear", 32'(ack_ok), 1);
    chk("clrA.vid_valid_errs", 32'(vv_err), 0);
    bad = 0;
    for (int i = 0; i < 2400; i++)
      if (i != 10 && mem[i] !== 16'h0020) bad++;
    chk("clrA.words_not_cleared", 32'(bad), 0);
    chk("clrA.cpu_word", 32'(mem[10]), 32'h7777);

    // Reset lands while the clear pointer is 1000
    fill = 1'b1;
    next_cycle();
    fill  = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      clr_start = (c == 0);
      @(negedge clk);
      if (ram_we && ram_addr == 12'd999) begin
        found = 1'b1;
        break;
      end
      next_cycle();
    end
    next_cycle();
    chk("rstC.reached_999", 32'(found), 1);
    clr_start = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    chk("rstC.we_in_reset", 32'(ram_we), 0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("rstC.busy_after", 32'(clr_busy), 0);
    chk("rstC.we_after", 32'(ram_we), 0);
    bad_lo = 0;
    bad_hi = 0;
    for (int i = 0; i < 1000; i++)    if (mem[i] !== 16'h0020) bad_lo++;
    for (int i = 1000; i < 2400; i++) if (mem[i] !== pat(i))   bad_hi++;
    chk("rstC.low_cleared", 32'(bad_lo), 0);
    chk("rstC.high_untouched", 32'(bad_hi), 0);

    // Reset coinciding with a CPU request leaves no ack behind
    next_cycle();
    reset    = 1'b1;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 12'd3;
    next_cycle();
    reset   = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    chk("rstcpu.ack", 32'(cpu_ack), 0);

    // Restart from address 0; a second clr_start while busy is ignored
    next_cycle();
    clr_start = 1'b1;
    @(negedge clk);
    chk("restart.busy_c0", 32'(clr_busy), 0);
    next_cycle();
    clr_start = 1'b0;
    @(negedge clk);
    chk("restart.busy_c1", 32'(clr_busy), 1);
    chk("restart.we_c1", 32'(ram_we), 1);
    chk("restart.addr_c1", 32'(ram_addr), 0);
    next_cycle();
    clr_start = 1'b1;
    @(negedge clk);
    chk("restart.addr_c2", 32'(ram_addr), 1);
    next_cycle();
    clr_start = 1'b0;
    @(negedge clk);
    chk("restart.addr_c3", 32'(ram_addr), 2);
    chk("restart.busy_c3", 32'(clr_busy), 1);
    next_cycle();
    busy_done = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!clr_busy) begin
        busy_done = 1'b1;
        break;
      end
      next_cycle();
    end
    chk("restart.done", 32'(busy_done), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tile_ram_arbiter.md
Name: tile_ram_arbiter

Overview:
- Owns the single port of the 80x30 text/tile RAM. Each 16-bit word holds the colour in [15:8] and the character code in [7:0].
- Shares that port between three requesters:
  - the VGA tile fetch path (one word per 8-pixel tile),
  - the MIPS core's memory-mapped text-buffer accesses,
  - an internal clear-screen engine.
- Video has strict priority so the display never tears. The CPU is held off with a req/ack handshake.

Parameters:
- COLS, 80, tiles per row.
- ROWS, 30, tile rows.
- ADDR_W, 12, word-address width (COLS*ROWS ≤ 2**ADDR_W).
- CLEAR_WORD, 16'h0020, word written by the clear engine (colour 00, space).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- vid_req  in  1  video fetch request, single-cycle pulse.
- vid_addr  in  ADDR_W  video word address.
- vid_valid  out  1  vid_rdata valid.
- vid_rdata  out  16  fetched tile word.
- cpu_req  in  1  CPU access request, held until ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  16  CPU write data.
- cpu_ack  out  1  one-cycle completion strobe.
- cpu_rdata  out  16  CPU read data, valid with cpu_ack.
- clr_start  in  1  start clear-screen, pulse.
- clr_busy  out  1  clear in progress.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write enable.
- ram_din  out  16  RAM write data.
- ram_dout  in  16  RAM read data, 1-cycle synchronous latency.

Behaviour:
- Clock and reset: one clock domain (clk). reset is synchronous and active-high.
- Reset values: every output is 0; FSM is IDLE; clear pointer is 0.
- Arbitration (combinational, per cycle), priority video > clear > CPU:
  - Video wins whenever vid_req=1.
  - Clear wins when clr_busy=1 and video is not requesting.
  - CPU wins when cpu_req=1, clr_busy=0, video is not requesting, and the CPU is not in its ack cycle.
- RAM port: the winner's ram_addr, ram_we and ram_din are driven combinationally in the grant cycle N. When nobody is granted, ram_we=0 and ram_addr holds its last value.
- Video path:
  - A vid_req in cycle N produces vid_valid=1 and vid_rdata=ram_dout in cycle N+1.
  - Latency is fixed at 1 cycle and never stalls.
  - vid_addr ≥ COLS*ROWS: the read is still issued, and vid_rdata=0 in N+1.
- CPU handshake:
  - The CPU is granted in cycle N. cpu_ack=1 for exactly cycle N+1, with cpu_rdata=ram_dout for reads and cpu_rdata=0 for writes.
  - In cycle N+1 (the ack cycle) the CPU is ineligible, so a held cpu_req is not issued twice.
  - A new request is eligible from cycle N+2.
  - cpu_addr ≥ COLS*ROWS: a write is suppressed (ram_we=0), a read returns 0; the access is still acked with normal timing.
  - The CPU must hold cpu_addr, cpu_we and cpu_wdata stable while cpu_req=1 and no ack has been seen.
- Clear engine FSM:
  - IDLE: clr_start=1 → CLEAR, ptr=0, clr_busy=1 from the next cycle.
  - CLEAR: in each cycle the clear is granted, write CLEAR_WORD to ptr and increment ptr. Cycles lost to video do not advance ptr.
  - CLEAR: after the write to ptr=COLS*ROWS-1 → IDLE, clr_busy=0 the next cycle.
  - clr_start while busy is ignored and does not restart the clear.
  - A CPU request pending during the clear waits; it is served after clr_busy falls.
- Clear duration with no video traffic: exactly COLS*ROWS (2400) cycles.
- Simultaneous events:
  - vid_req and cpu_req in the same cycle: video is served and the CPU waits one more cycle.
  - clr_start and cpu_req in the same IDLE cycle: the CPU is granted that cycle and the clear starts next cycle.
- Reset mid-operation: reset mid-clear aborts the clear (remaining words untouched, clr_busy=0). Reset during a CPU access drops its pending ack.
- Bandwidth guarantee: video requests at most 1 per 8 cycles, so a CPU request waits at most 2 cycles when no clear is running.

Test Plan:
- Reset → all outputs 0. CPU write 16'h1C41 to addr 0, then read addr 0 → first cpu_ack 1 cycle after grant; the read returns 16'h1C41 with cpu_ack.
- vid_req and cpu_req (read, addr 5) in the same cycle → vid_valid next cycle; CPU granted one cycle later; cpu_ack 2 cycles after request.
- CPU holds cpu_req=1 for 6 cycles (addr 7, write) → exactly one ram_we pulse and one cpu_ack pulse per issued access, with no back-to-back issue.
- clr_start with vid_req every 8th cycle → all 2400 words equal 16'h0020; clr_busy drops after 2400+(video-stolen) cycles. A CPU write issued during the clear is acked only after clr_busy=0.
- CPU write to addr 2400 → cpu_ack asserted, ram_we stays 0, RAM unchanged. Read at 4095 returns 0.
- Assert reset at clear ptr=1000 → clr_busy=0 next cycle; words ≥1000 keep their old contents. A new clr_start restarts from addr 0.
